icache_controller: RTL and testbench
====================================

ICACHE_CONTROLLER -- requirements
Module: icache_controller

Interface
REQ-001 SHALL have parameter LINE_COUNT, default 256, number of cache lines (index width = $clog2(LINE_COUNT) = 8).
REQ-002 SHALL have parameter TAG_WIDTH, default 20, tag bits per line (addr[31:12]).
REQ-003 SHALL have parameter BLOCK_WIDTH, default 128, data bits per line (4 x 32-bit words).
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_valid_i  input  1  fetch request.
REQ-007 req_addr_i  input  32  fetch byte address; addr[1:0] ignored.
REQ-008 req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-009 resp_valid_o  output  1  one-cycle pulse; instruction valid.
REQ-010 resp_instr_o  output  32  fetched instruction.
REQ-011 flush_i  input  1  invalidate all lines.
REQ-012 mem_req_o  output  1  line refill request to main memory.
REQ-013 mem_addr_o  output  32  line-aligned refill address {tag, index, 4'b0}.
REQ-014 mem_valid_i  input  1  refill data valid (single beat).
REQ-015 mem_data_i  input  128  refill line; word 0 = bits [31:0].
REQ-016 bram_cmd_en_o, bram_wr_en_o  output  1 each  BRAM command/write enables.
REQ-017 bram_addr_o  output  8  BRAM line index.
REQ-018 bram_data_o  output  148  write line {tag[147:128], block[127:0]}.
REQ-019 bram_data_i  input  148  BRAM read data, valid one cycle after read command, held until next read.
REQ-020 hit_count_o, miss_count_o  output  32 each  performance counters.

Function
REQ-021 Address split: tag = addr[31:12], index = addr[11:4], word = addr[3:2].
REQ-022 SHALL hold one valid bit per line in registers (BRAM line carries no valid bit).
REQ-023 FSM states: IDLE, LOOKUP, MEM_WAIT, REFILL.
REQ-024 req_ready_o = 1 only in IDLE with flush_i low and no pending flush.
REQ-025 IDLE, request accepted: latch address; same cycle drive bram_cmd_en_o=1, bram_wr_en_o=0, bram_addr_o=index; next state LOOKUP.
REQ-026 LOOKUP: hit = valid[index] && bram_data_i[147:128]==tag.
REQ-027 Hit: next cycle resp_valid_o=1, resp_instr_o = selected word of bram_data_i; hit_count_o +1; -> IDLE. Hit latency: accept at cycle 0, response at cycle 2.
REQ-028 Miss: miss_count_o +1; -> MEM_WAIT; mem_req_o=1 from next cycle.
REQ-029 MEM_WAIT: mem_req_o and mem_addr_o held stable until mem_valid_i; on mem_valid_i capture mem_data_i, -> REFILL; mem_req_o low next cycle.
REQ-030 REFILL (one cycle): bram_cmd_en_o=1, bram_wr_en_o=1, bram_addr_o=index, bram_data_o={tag, captured line}; set valid[index]; next cycle resp_valid_o=1 with selected word from captured line; -> IDLE.
REQ-031 mem_valid_i outside MEM_WAIT SHALL be ignored.
REQ-032 bram_cmd_en_o SHALL be 0 in all cycles except REQ-025 and REQ-030.
REQ-033 flush_i in IDLE: clear all valid bits that cycle; no request accepted that cycle.
REQ-034 flush_i outside IDLE: latch as pending; applied on the first IDLE cycle (after any REFILL valid-set), before the next request.
REQ-035 Counters wrap modulo 2^32; flush does not clear them.

Reset
REQ-036 rst_i SHALL, at any state including mid-refill: state=IDLE, all valid bits 0, pending flush 0, resp_valid_o=0, resp_instr_o=0, mem_req_o=0, mem_addr_o=0, bram_cmd_en_o=0, bram_wr_en_o=0, bram_addr_o=0, bram_data_o=0, counters 0; req_ready_o=1 the cycle after reset deasserts.

Verification
REQ-037 Cold miss: after reset, fetch 0x0000_1234 -> mem_req_o=1, mem_addr_o=0x0000_1230; return 0x44444444_33333333_22222222_11111111 -> BRAM write index 0x23, tag 0x00001; resp_instr_o=0x22222222; miss_count_o=1.
REQ-038 Hit: then fetch 0x0000_123C -> no mem_req_o; resp_instr_o=0x44444444 exactly 2 cycles after acceptance; hit_count_o=1.
REQ-039 Conflict: fetch 0x0000_2230 (same index 0x23, tag 0x00002) -> miss, refill overwrites line; subsequent 0x0000_1230 misses again.
REQ-040 Flush: flush_i during MEM_WAIT -> refill completes with response; req_ready_o low one IDLE cycle; next fetch of same address misses.
REQ-041 Reset mid-operation: rst_i in MEM_WAIT -> mem_req_o=0 next cycle; late mem_valid_i ignored, no resp_valid_o, no BRAM write.
REQ-042 Back-to-back: req_valid_i held high over 8 hits -> one response per 2 cycles, req_ready_o high only in IDLE.

Source files
------------

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: one-cycle BRAM lookup, single-beat refill.
// State table: IDLE = accept requests and apply flushes | LOOKUP = compare tag and valid bit | MEM_WAIT = refill outstanding | REFILL = write line and respond
module icache_controller #(
  parameter int LINE_COUNT  = 256,
  parameter int TAG_WIDTH   = 20,
  parameter int BLOCK_WIDTH = 128,
  localparam int IDX_W      = $clog2(LINE_COUNT),
  localparam int LINE_W     = TAG_WIDTH + BLOCK_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [31:0]       req_addr_i,
  output logic              req_ready_o,
  output logic              resp_valid_o,
  output logic [31:0]       resp_instr_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [BLOCK_WIDTH-1:0] mem_data_i,
  output logic              bram_cmd_en_o,
  output logic              bram_wr_en_o,
  output logic [IDX_W-1:0]  bram_addr_o,
  output logic [LINE_W-1:0] bram_data_o,
  input  logic [LINE_W-1:0] bram_data_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WAIT, REFILL} state_t;

  state_t                 state_q, state_d;
  logic [31:2]            addr_q;
  logic [LINE_COUNT-1:0]  valid_q;
  logic                   flush_pend_q;
  logic [BLOCK_WIDTH-1:0] line_q;

  logic [IDX_W-1:0]       req_idx, lat_idx;
  logic [TAG_WIDTH-1:0]   lat_tag;
  logic [1:0]             lat_word;
  logic                   accept, hit;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[1:0];

  assign req_idx  = req_addr_i[4 +: IDX_W];
  assign lat_idx  = addr_q[4 +: IDX_W];
  assign lat_tag  = addr_q[31 -: TAG_WIDTH];
  assign lat_word = addr_q[3:2];

  assign req_ready_o = !rst_i && (state_q == IDLE) && !flush_i && !flush_pend_q;
  assign accept      = req_valid_i && req_ready_o;
  assign hit         = valid_q[lat_idx] && (bram_data_i[LINE_W-1 -: TAG_WIDTH] == lat_tag);

  function automatic logic [31:0] sel_word(input logic [BLOCK_WIDTH-1:0] blk, input logic [1:0] w);
    return blk[32*w +: 32];
  endfunction

  always_comb begin
    state_d       = state_q;
    bram_cmd_en_o = 1'b0;
    bram_wr_en_o  = 1'b0;
    bram_addr_o   = '0;
    bram_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bram_cmd_en_o = 1'b1;
          bram_addr_o   = req_idx;
          state_d       = LOOKUP;
        end
      end
      LOOKUP:   state_d = hit ? IDLE : MEM_WAIT;
      MEM_WAIT: if (mem_valid_i) state_d = REFILL;
      REFILL: begin
        bram_cmd_en_o = 1'b1;
        bram_wr_en_o  = 1'b1;
        bram_addr_o   = lat_idx;
        bram_data_o   = {lat_tag, line_q};
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Keep the BRAM quiet while reset is held, whatever state we were in.
    if (rst_i) begin
      bram_cmd_en_o = 1'b0;
      bram_wr_en_o  = 1'b0;
      bram_addr_o   = '0;
      bram_data_o   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      line_q       <= '0;
      resp_valid_o <= 1'b0;
      resp_instr_o <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_o <= 1'b0;
      if (accept) addr_q <= req_addr_i[31:2];
      if (flush_i && state_q != IDLE) flush_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (flush_i || flush_pend_q) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_o <= 1'b1;
            resp_instr_o <= sel_word(bram_data_i[BLOCK_WIDTH-1:0], lat_word);
            hit_count_o  <= hit_count_o + 32'd1;
          end else begin
            miss_count_o <= miss_count_o + 32'd1;
            mem_req_o    <= 1'b1;
            mem_addr_o   <= {addr_q[31:4], 4'b0000};
          end
        end
        MEM_WAIT: begin
          if (mem_valid_i) begin
            line_q    <= mem_data_i;
            mem_req_o <= 1'b0;
          end
        end
        REFILL: begin
          valid_q[lat_idx] <= 1'b1;
          resp_valid_o     <= 1'b1;
          resp_instr_o     <= sel_word(line_q, lat_word);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller: BRAM model, scoreboard of expected instructions.
module tb_icache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic [31:0]  req_addr_i;
  logic         req_ready_o;
  logic         resp_valid_o;
  logic [31:0]  resp_instr_o;
  logic         flush_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_valid_i;
  logic [127:0] mem_data_i;
  logic         bram_cmd_en_o, bram_wr_en_o;
  logic [7:0]   bram_addr_o;
  logic [147:0] bram_data_o;
  logic [147:0] bram_data_i;
  logic [31:0]  hit_count_o, miss_count_o;

  icache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o), .resp_instr_o(resp_instr_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .bram_cmd_en_o(bram_cmd_en_o), .bram_wr_en_o(bram_wr_en_o),
    .bram_addr_o(bram_addr_o), .bram_data_o(bram_data_o), .bram_data_i(bram_data_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_cnt = 0;
  int bram_wr_cnt = 0;
  int last_resp_cyc = 0;
  logic [31:0] exp_q[$];
  int resp_cycles[$];
  logic [147:0] bram_mem [256];

  localparam logic [127:0] LINE1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] LINE3 = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (bram_cmd_en_o) begin
      if (bram_wr_en_o) begin
        bram_mem[bram_addr_o] <= bram_data_o;
        bram_wr_cnt <= bram_wr_cnt + 1;
      end else begin
        bram_data_i <= bram_mem[bram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [147:0] obs, input logic [147:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      if (exp_q.size() == 0) chk("resp_unexpected", resp_valid_o, 1'b0);
      else chk("resp_instr", resp_instr_o, exp_q.pop_front());
      resp_cnt++;
      last_resp_cyc = cyc;
      resp_cycles.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int acc);
    int n = 0;
    req_addr_i  = a;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 20) begin tick(); n++; end
    chk("req_ready_wait", req_ready_o, 1'b1);
    tick();
    acc = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_mem_req(input logic [31:0] exp_addr);
    int n = 0;
    while (!mem_req_o && n < 20) begin tick(); n++; end
    chk("mem_req_seen", mem_req_o, 1'b1);
    chk("mem_addr", mem_addr_o, exp_addr);
  endtask

  task automatic give_line(input logic [127:0] line);
    mem_valid_i = 1'b1;
    mem_data_i  = line;
    tick();
    mem_valid_i = 1'b0;
    mem_data_i  = '0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 20) begin tick(); n++; end
    chk("resp_count", resp_cnt, target);
  endtask

  initial begin
    int acc;
    int wr_before, resp_before;
    for (int i = 0; i < 256; i++) bram_mem[i] = '0;
    bram_data_i = '0;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
    mem_valid_i = 1'b0; mem_data_i = '0;
    repeat (3) tick();

    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_bram_cmd", bram_cmd_en_o, 1'b0);
    chk("rst_hits", hit_count_o, 32'h0);
    chk("rst_misses", miss_count_o, 32'h0);
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", req_ready_o, 1'b1);

    // Cold miss on 0x1234
    exp_q.push_back(32'h22222222);
    fetch(32'h0000_1234, acc);
    wait_mem_req(32'h0000_1230);
    repeat (3) begin
      tick();
      chk("mem_req_held", mem_req_o, 1'b1);
      chk("mem_addr_held", mem_addr_o, 32'h0000_1230);
    end
    chk("no_resp_while_waiting", resp_cnt, 0);
    give_line(LINE1);
    chk("refill_cmd_en", bram_cmd_en_o, 1'b1);
    chk("refill_wr_en", bram_wr_en_o, 1'b1);
    chk("refill_index", bram_addr_o, 8'h23);
    chk("refill_tag", bram_data_o[147:128], 20'h00001);
    chk("refill_block", bram_data_o[127:0], LINE1);
    chk("mem_req_drop", mem_req_o, 1'b0);
    wait_resp(1);
    chk("miss_count_cold", miss_count_o, 32'd1);
    chk("bram_writes_cold", bram_wr_cnt, 1);

    // Hit on same line, word 3
    exp_q.push_back(32'h44444444);
    fetch(32'h0000_123C, acc);
    chk("hit_no_mem_req", mem_req_o, 1'b0);
    wait_resp(2);
    chk("hit_latency_cycle", last_resp_cyc - acc + 1, 2);
    chk("hit_count_1", hit_count_o, 32'd1);
    chk("miss_count_after_hit", miss_count_o, 32'd1);

    // Conflict: same index, tag 2, then the evicted line misses again
    exp_q.push_back(32'h55555555);
    fetch(32'h0000_2230, acc);
    wait_mem_req(32'h0000_2230);
    give_line(LINE2);
    chk("conflict_tag", bram_data_o[147:128], 20'h00002);
    wait_resp(3);
    exp_q.push_back(32'h11111111);
    fetch(32'h0000_1230, acc);
    wait_mem_req(32'h0000_1230);
    give_line(LINE1);
    wait_resp(4);
    chk("miss_count_conflict", miss_count_o, 32'd3);
    chk("hit_count_conflict", hit_count_o, 32'd1);

    // Flush while a refill is outstanding
    exp_q.push_back(32'haaaaaaaa);
    fetch(32'h0000_5670, acc);
    wait_mem_req(32'h0000_5670);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    give_line(LINE3);
    chk("flush_refill_wr", bram_wr_en_o, 1'b1);
    tick();
    chk("flush_ready_low", req_ready_o, 1'b0);
    tick();
    chk("flush_ready_back", req_ready_o, 1'b1);
    wait_resp(5);
    exp_q.push_back(32'haaaaaaaa);
    fetch(32'h0000_5670, acc);
    wait_mem_req(32'h0000_5670);
    give_line(LINE3);
    wait_resp(6);
    chk("miss_count_flush", miss_count_o, 32'd5);

    // Reset while waiting on memory; late data must be ignored
    fetch(32'h0000_9990, acc);
    wait_mem_req(32'h0000_9990);
    rst_i = 1'b1;
    tick();
    chk("midrst_mem_req", mem_req_o, 1'b0);
    chk("midrst_hits", hit_count_o, 32'h0);
    chk("midrst_misses", miss_count_o, 32'h0);
    rst_i = 1'b0;
    wr_before = bram_wr_cnt;
    resp_before = resp_cnt;
    mem_valid_i = 1'b1;
    mem_data_i = LINE2;
    #1;
    chk("late_data_no_cmd", bram_cmd_en_o, 1'b0);
    tick();
    mem_valid_i = 1'b0;
    chk("late_data_no_cmd2", bram_cmd_en_o, 1'b0);
    repeat (3) tick();
    chk("late_data_no_write", bram_wr_cnt, wr_before);
    chk("late_data_no_resp", resp_cnt, resp_before);
    chk("midrst_ready", req_ready_o, 1'b1);

    // Refill once, then eight back-to-back hits
    exp_q.push_back(32'h11111111);
    fetch(32'h0000_1230, acc);
    wait_mem_req(32'h0000_1230);
    give_line(LINE1);
    wait_resp(resp_before + 1);
    resp_cycles.delete();
    req_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr_i = 32'h0000_1230 + 32'(4 * (i % 4));
      exp_q.push_back(LINE1[32*(i%4) +: 32]);
      #1;
      chk("b2b_ready_idle", req_ready_o, 1'b1);
      tick();
      chk("b2b_ready_lookup", req_ready_o, 1'b0);
      tick();
    end
    req_valid_i = 1'b0;
    wait_resp(resp_before + 9);
    chk("b2b_resp_total", resp_cycles.size(), 8);
    for (int i = 1; i < resp_cycles.size(); i++)
      chk("b2b_resp_gap", resp_cycles[i] - resp_cycles[i-1], 2);
    chk("b2b_hits", hit_count_o, 32'd8);
    chk("b2b_misses", miss_count_o, 32'd1);
    chk("b2b_no_mem_req", mem_req_o, 1'b0);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
